// File: rtl/png_chunk_framer_pkg.sv
// ============================================================================
// Module   : png_pkg
// Brief    : Shared types, constants and CRC helper for the PNG chunk framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package png_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_TYP  = 3'd2,
        S_DAT  = 3'd3,
        S_WCRC = 3'd4,
        S_CRC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [31:0] PNG_MAX_LEN   = 32'h7FFF_FFFF;
    localparam logic [31:0] PNG_TYPE_IHDR = 32'h4948_4452;
    localparam logic [31:0] PNG_TYPE_IDAT = 32'h4944_4154;
    localparam logic [31:0] PNG_TYPE_IEND = 32'h4945_4E44;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

    // Reflected CRC-32 (zlib) update by one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc ^ {24'h0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] msb_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/png_chunk_framer_if.sv
// ============================================================================
// Module   : png_chunk_framer_if
// Brief    : Request, payload-in and byte-out signals of the PNG chunk framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface png_chunk_framer_if #(
    parameter int LEN_W = 32
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0]      typ_i;
    logic             val_i;
    logic [7:0]       dat_i;
    logic             rdy_o;
    logic             val_o;
    logic [7:0]       dat_o;
    logic             lst_o;
    logic             rdy_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport master (
        output start_i, len_i, typ_i, val_i, dat_i, rdy_i,
        input  rdy_o, val_o, dat_o, lst_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, len_i, typ_i, val_i, dat_i, rdy_i,
        output rdy_o, val_o, dat_o, lst_o, busy_o, done_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/png_chunk_framer_crc32.sv
// ============================================================================
// Module   : crc32
// Brief    : Byte-serial zlib CRC-32; result valid one cycle after the last byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32
    import png_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        start_i,
    input  wire logic        val_i,
    input  wire logic [7:0]  dat_i,
    input  wire logic        lst_i,
    output logic             val_o,
    output logic [31:0]      dat_o
);

    logic [31:0] r_crc;
    logic        r_val;
    logic [31:0] r_dat;
    logic [31:0] w_next;

    assign w_next = crc32_byte(r_crc, dat_i);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_crc <= 32'hFFFF_FFFF;
            r_val <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_val <= 1'b0;
            if (start_i) begin
                r_crc <= 32'hFFFF_FFFF;
            end else if (val_i) begin
                r_crc <= w_next;
                if (lst_i) begin
                    r_val <= 1'b1;
                    r_dat <= ~w_next;
                end
            end
        end
    end

    assign val_o = r_val;
    assign dat_o = r_dat;

endmodule

`default_nettype wire

// File: rtl/png_chunk_framer.sv
// ============================================================================
// Module   : png_chunk_framer
// Brief    : Emits length, type, payload and CRC of one PNG chunk as bytes.
//            Optional PNG_LEN_CHK_EN rejects lengths above the PNG limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module png_chunk_framer
    import png_pkg::*;
#(
    parameter int LEN_W = 32
)(
    input  wire logic         clk,
    input  wire logic         rst,
    png_chunk_framer_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rem;
    logic [31:0]      r_typ;
    logic [31:0]      r_crc;
    logic [1:0]       r_bcnt;

    logic [31:0]      w_len32;
    logic             w_len_bad;
    logic             w_val_o;
    logic [7:0]       w_dat_o;
    logic             w_lst_o;
    logic             w_rdy_o;
    logic             w_busy;
    logic             w_done;
    logic             w_hdr_xfer;
    logic             w_dat_xfer;
    logic             w_crc_start;
    logic             w_crc_val;
    logic [7:0]       w_crc_dat;
    logic             w_crc_lst;
    logic             w_crc_vo;
    logic [31:0]      w_crc_do;

    assign w_len32 = 32'(r_len);

`ifdef PNG_LEN_CHK_EN
    logic r_err;

    assign w_len_bad = (32'(bus.len_i) > PNG_MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && bus.start_i && w_len_bad;
        end
    end

    assign bus.err_o = r_err;
`else
    assign w_len_bad = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_val_o     = 1'b0;
        w_dat_o     = 8'h00;
        w_lst_o     = 1'b0;
        w_rdy_o     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_hdr_xfer  = 1'b0;
        w_dat_xfer  = 1'b0;
        w_crc_start = 1'b0;
        w_crc_val   = 1'b0;
        w_crc_dat   = 8'h00;
        w_crc_lst   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i && !w_len_bad) begin
                    w_crc_start = 1'b1;
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                w_busy     = 1'b1;
                w_val_o    = 1'b1;
                w_dat_o    = msb_byte(w_len32, r_bcnt);
                w_hdr_xfer = bus.rdy_i;
                if (bus.rdy_i && (r_bcnt == 2'd3)) begin
                    w_state_nxt = S_TYP;
                end
            end
            S_TYP: begin
                w_busy     = 1'b1;
                w_val_o    = 1'b1;
                w_dat_o    = msb_byte(r_typ, r_bcnt);
                w_hdr_xfer = bus.rdy_i;
                // The CRC engine has no backpressure, so feed it only on transfers.
                if (bus.rdy_i) begin
                    w_crc_val = 1'b1;
                    w_crc_dat = w_dat_o;
                    if (r_bcnt == 2'd3) begin
                        w_crc_lst   = (r_len == '0);
                        w_state_nxt = (r_len == '0) ? S_WCRC : S_DAT;
                    end
                end
            end
            S_DAT: begin
                w_busy     = 1'b1;
                w_val_o    = bus.val_i;
                w_dat_o    = bus.dat_i;
                w_rdy_o    = bus.rdy_i;
                w_dat_xfer = bus.val_i && bus.rdy_i;
                if (w_dat_xfer) begin
                    w_crc_val = 1'b1;
                    w_crc_dat = bus.dat_i;
                    if (r_rem == LEN_W'(1)) begin
                        w_crc_lst   = 1'b1;
                        w_state_nxt = S_WCRC;
                    end
                end
            end
            S_WCRC: begin
                w_busy = 1'b1;
                if (w_crc_vo) begin
                    w_state_nxt = S_CRC;
                end
            end
            S_CRC: begin
                w_busy     = 1'b1;
                w_val_o    = 1'b1;
                w_dat_o    = msb_byte(r_crc, r_bcnt);
                w_lst_o    = (r_bcnt == 2'd3);
                w_hdr_xfer = bus.rdy_i;
                if (bus.rdy_i && (r_bcnt == 2'd3)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_rem   <= '0;
            r_typ   <= 32'h0;
            r_crc   <= 32'h0;
            r_bcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_crc_start) begin
                r_len  <= bus.len_i;
                r_rem  <= bus.len_i;
                r_typ  <= bus.typ_i;
                r_bcnt <= 2'd0;
            end
            if (w_hdr_xfer) begin
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (w_dat_xfer) begin
                r_rem <= r_rem - LEN_W'(1);
            end
            if ((r_state == S_WCRC) && w_crc_vo) begin
                r_crc <= w_crc_do;
            end
        end
    end

    crc32 u_crc32 (
        .clk     (clk),
        .rstn    (~rst),
        .start_i (w_crc_start),
        .val_i   (w_crc_val),
        .dat_i   (w_crc_dat),
        .lst_i   (w_crc_lst),
        .val_o   (w_crc_vo),
        .dat_o   (w_crc_do)
    );

    assign bus.val_o  = w_val_o;
    assign bus.dat_o  = w_dat_o;
    assign bus.lst_o  = w_lst_o;
    assign bus.rdy_o  = w_rdy_o;
    assign bus.busy_o = w_busy;
    assign bus.done_o = w_done;

endmodule

`default_nettype wire

// File: tb/tb_png_chunk_framer.sv
// ============================================================================
// Module   : tb_png_chunk_framer
// Brief    : Directed, table-driven bench for png_chunk_framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_png_chunk_framer;
    import png_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    png_chunk_framer_if #(.LEN_W(32)) bus ();

    png_chunk_framer #(.LEN_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]  typ;
        logic [31:0]  len;
        logic [103:0] pl;     // payload, byte 0 in the top byte
        logic [31:0]  crc;
        bit           stall;
        bit           inj;    // pulse start_i while the chunk is busy
    } vec_t;

    vec_t vt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] typ, input logic [103:0] pl, input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 4 + n; i++) begin
            b = (i < 4) ? typ[31-8*i -: 8] : pl[103-8*(i-4) -: 8];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic idle_inputs();
        bus.start_i = 1'b0;
        bus.len_i   = 32'h0;
        bus.typ_i   = 32'h0;
        bus.val_i   = 1'b0;
        bus.dat_i   = 8'h00;
        bus.rdy_i   = 1'b0;
    endtask

    task automatic run_chunk(input vec_t v, input string tag);
        logic [7:0] expb [0:31];
        int  total, nout, pidx, plen;
        bit  done_seen, rdy_seen;
        plen  = int'(v.len);
        total = 12 + plen;
        for (int i = 0; i < 4; i++) begin
            expb[i]             = v.len[31-8*i -: 8];
            expb[4+i]           = v.typ[31-8*i -: 8];
            expb[8+plen+i]      = v.crc[31-8*i -: 8];
        end
        for (int k = 0; k < plen; k++) expb[8+k] = v.pl[103-8*k -: 8];

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = v.len;
        bus.typ_i   = v.typ;
        bus.val_i   = 1'b0;
        bus.rdy_i   = 1'b0;
        #1;
        check({tag, " idle_before_start"}, {30'h0, bus.busy_o, bus.val_o}, 32'h0);
        @(posedge clk);

        nout = 0; pidx = 0; done_seen = 0; rdy_seen = 0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            @(negedge clk);
            bus.start_i = v.inj && (cyc >= 2) && (cyc < 6);
            bus.len_i   = 32'h0;
            bus.typ_i   = PNG_TYPE_IEND;
            bus.rdy_i   = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.val_i   = (pidx < plen);
            bus.dat_i   = (pidx < plen) ? v.pl[103-8*pidx -: 8] : 8'h00;
            #1;
            if (bus.rdy_o) rdy_seen = 1;
            if (bus.done_o) begin
                done_seen = 1;
                check({tag, " bytes_before_done"}, nout, total);
            end
            if (bus.val_o && bus.rdy_i) begin
                if (nout < total) begin
                    check($sformatf("%s byte%0d", tag, nout), {24'h0, bus.dat_o}, {24'h0, expb[nout]});
                    check($sformatf("%s lst%0d", tag, nout), {31'h0, bus.lst_o}, {31'h0, (nout == total - 1)});
                end else begin
                    check({tag, " extra_byte"}, nout, total - 1);
                end
                nout++;
            end
            if (bus.rdy_o && bus.val_i) pidx++;
        end
        bus.start_i = 1'b0;
        bus.val_i   = 1'b0;
        check({tag, " done_seen"}, {31'h0, done_seen}, 32'h1);
        check({tag, " payload_taken"}, pidx, plen);
        if (plen == 0) check({tag, " rdy_o_never_high"}, {31'h0, rdy_seen}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit in_dat;
        logic [7:0] big [0:3];
        idle_inputs();

        vt[0] = '{typ: PNG_TYPE_IEND, len: 32'd0, pl: 104'h0, crc: 32'hAE42_6082, stall: 1'b0, inj: 1'b0};
        vt[1] = '{typ: PNG_TYPE_IDAT, len: 32'd3, pl: {24'h010203, 80'h0}, crc: 32'h0, stall: 1'b1, inj: 1'b0};
        vt[1].crc = crc_model(vt[1].typ, vt[1].pl, 3);
        vt[2] = '{typ: PNG_TYPE_IHDR, len: 32'd13, pl: 104'h00000001_00000001_08_02_00_00_00,
                  crc: 32'h9077_53DE, stall: 1'b0, inj: 1'b1};
        vt[3] = '{typ: PNG_TYPE_IEND, len: 32'd0, pl: 104'h0, crc: 32'hAE42_6082, stall: 1'b1, inj: 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_flags", {25'h0, bus.val_o, bus.rdy_o, bus.lst_o, bus.busy_o, bus.done_o, bus.err_o, 1'b0}, 32'h0);
        check("reset_dat_o", {24'h0, bus.dat_o}, 32'h0);
        rst = 1'b0;

        run_chunk(vt[0], "iend");
        run_chunk(vt[1], "idat_stall");
        run_chunk(vt[2], "ihdr_b2b");
        run_chunk(vt[3], "iend_b2b");

        // Reset while in DAT
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = 32'd3;
        bus.typ_i   = PNG_TYPE_IDAT;
        @(posedge clk);
        in_dat = 0;
        for (int cyc = 0; cyc < 20 && !in_dat; cyc++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.rdy_i   = 1'b1;
            bus.val_i   = 1'b1;
            bus.dat_i   = 8'h01;
            #1;
            if (bus.rdy_o) in_dat = 1;
        end
        check("reached_dat", {31'h0, in_dat}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", {29'h0, bus.val_o, bus.rdy_o, bus.busy_o}, 32'h0);
        idle_inputs();
        run_chunk(vt[0], "iend_after_reset");

        // Length above the PNG limit
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = 32'h8000_0000;
        bus.typ_i   = PNG_TYPE_IDAT;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.rdy_i   = 1'b1;
`ifdef PNG_LEN_CHK_EN
        #1;
        check("big_len_err", {31'h0, bus.err_o}, 32'h1);
        check("big_len_busy", {31'h0, bus.busy_o}, 32'h0);
        begin
            int nv;
            nv = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                if (bus.val_o || bus.busy_o || bus.err_o) nv++;
            end
            check("big_len_quiet", nv, 0);
        end
`else
        big[0] = 8'h80; big[1] = 8'h00; big[2] = 8'h00; big[3] = 8'h00;
        #1;
        check("big_len_err", {31'h0, bus.err_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("big_len_byte%0d", i), {23'h0, bus.val_o, bus.dat_o}, {23'h0, 1'b1, big[i]});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`endif
        idle_inputs();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/png_chunk_framer.md
Name: png_chunk_framer

Overview:
- Sequences one shared crc32 instance to build a complete PNG chunk as a byte stream: 4-byte length, 4-byte type, payload, then 4-byte CRC.
- Sits between the chunk producers (IHDR/IDAT/IEND writers) and the output byte sink.
- The CRC covers type plus payload, not the length field.

Parameters:
- LEN_W, 32, width of the payload length counter; lengths are zero-extended to 32 bits on output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  one-cycle chunk request; sampled only in IDLE
- len_i  in  LEN_W  payload byte count, captured with start_i
- typ_i  in  32  chunk type, MSB byte first (e.g. 0x49454E44 = "IEND"), captured with start_i
- val_i  in  1  payload byte valid
- dat_i  in  8  payload byte
- rdy_o  out  1  payload byte accepted when val_i & rdy_o
- val_o  out  1  output byte valid
- dat_o  out  8  output byte
- lst_o  out  1  marks the last CRC byte of the chunk
- rdy_i  in  1  sink ready; a byte transfers when val_o & rdy_i
- busy_o  out  1  high from start acceptance until done
- done_o  out  1  one-cycle pulse after the last byte transfers
- err_o  out  1  one-cycle pulse on a rejected request (feature only)

Behaviour:
- Reset: state IDLE; rdy_o, val_o, lst_o, busy_o, done_o, err_o all 0; dat_o = 0; counters cleared. crc32 is reset via rstn = ~rst. Reset mid-chunk abandons the chunk and emits no further bytes.
- FSM: IDLE -> LEN -> TYP -> DAT -> WCRC -> CRC -> DONE -> IDLE.
- IDLE:
  - start_i latches len_i and typ_i, pulses crc32 start_i the same cycle, goes to LEN.
  - start_i is ignored when not in IDLE.
- LEN: val_o = 1; dat_o = len bytes MSB first; advance byte on rdy_i; after 4 transfers go to TYP.
- TYP:
  - Same 4-byte, MSB-first sequence for type.
  - Each transferred byte is also driven into crc32 (val_i = 1, dat_i = byte) in the same cycle.
  - On the 4th byte, crc32 lst_i = 1 if len == 0, and the FSM goes to WCRC; otherwise it goes to DAT.
- DAT:
  - Combinational pass-through: val_o = val_i, dat_o = dat_i, rdy_o = rdy_i.
  - Each transfer feeds crc32 and decrements the remaining count.
  - On the transfer that brings the count to 0, crc32 lst_i = 1 and the FSM goes to WCRC.
  - rdy_o = 0 in every other state.
- crc32 drive rules:
  - crc32 takes at most one byte per cycle with no backpressure, so the framer asserts crc32 val_i only in a transfer cycle.
  - Output stalls (rdy_i = 0) therefore also stall CRC feeding.
- WCRC:
  - val_o = 0; wait for crc32 val_o, then latch crc32 dat_o into a 32-bit register and go to CRC.
  - No timeout.
- CRC:
  - Emit the latched CRC MSB first.
  - lst_o = 1 with the 4th byte; after that transfer go to DONE.
- DONE: done_o = 1 for one cycle, busy_o drops, return to IDLE. Back-to-back start_i is accepted in the IDLE cycle that follows.
- Widths and bounds:
  - Counters are 2-bit for header/CRC bytes and LEN_W-bit for payload; no wrap is possible.
  - len_i = 0 skips DAT entirely.
  - A payload byte presented outside DAT is not accepted.

Optional Feature:
- Macro: PNG_LEN_CHK_EN.
- Defined: start_i with a 32-bit zero-extended length > 0x7FFFFFFF (PNG limit) is rejected. err_o pulses 1 cycle, the FSM stays IDLE, and crc32 is not started.
- Undefined: err_o is tied to 0 and every length is accepted.

Decomposition:
- Shared package png_pkg:
  - FSM state enum
  - PNG_MAX_LEN = 32'h7FFFFFFF
  - chunk type constants (IHDR 0x49484452, IDAT 0x49444154, IEND 0x49454E44)
- One sub-module: the existing crc32, instantiated once inside this block.

Test Plan:
- IEND, len 0, rdy_i = 1:
  - Output 00 00 00 00 49 45 4E 44 AE 42 60 82.
  - lst_o on 0x82, done_o the next cycle.
  - rdy_o never high.
- IDAT, len 3, payload 01 02 03, random rdy_i stalls:
  - Byte sequence and CRC match the zlib crc32 golden model over "IDAT" + payload.
  - No byte is duplicated or lost during stalls.
- Two back-to-back chunks (IHDR with 13 golden bytes, then IEND):
  - start_i pulsed during busy is ignored.
  - The second chunk starts only after done_o.
  - Both CRCs are correct.
- Reset asserted mid-DAT:
  - Next cycle val_o = rdy_o = busy_o = 0.
  - A subsequent IEND request produces the exact 12-byte IEND sequence.
- PNG_LEN_CHK_EN defined, len_i = 0x80000000:
  - err_o pulses, busy_o stays 0, no output bytes.
  - Without the macro, the same request enters LEN and emits 80 00 00 00.
